// File: rtl/segment_led_pkg.sv
// Shared definitions for the segment_led display path.
// Contents: FSM state encodings for bcd_segment_feeder, segment constants,
// the 7-segment font lookup and a power-of-ten helper for overflow limits.
package segment_led_pkg;

  // Feeder FSM states
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StShift  = 2'd1;
  localparam logic [1:0] StEncode = 2'd2;

  // Active-high patterns, bit0..6 = a..g, bit7 = dp
  localparam logic [7:0] SEG_MINUS = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Decimal font; codes 10..15 never come out of a valid BCD nibble and map to blank
  function automatic logic [7:0] seg_font(input logic [3:0] nibble);
    case (nibble)
      4'd0:    seg_font = 8'h3F;
      4'd1:    seg_font = 8'h06;
      4'd2:    seg_font = 8'h5B;
      4'd3:    seg_font = 8'h4F;
      4'd4:    seg_font = 8'h66;
      4'd5:    seg_font = 8'h6D;
      4'd6:    seg_font = 8'h7D;
      4'd7:    seg_font = 8'h07;
      4'd8:    seg_font = 8'h7F;
      4'd9:    seg_font = 8'h6F;
      default: seg_font = SEG_BLANK;
    endcase
  endfunction

  // 10**n without 32-bit int overflow for wide displays
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   start_i        load value_i and begin a conversion
//   value_i        unsigned binary input
//   busy_o         conversion in progress
//   done_o         high during the final shift cycle (combinational)
//   bcd_o          packed BCD result, nibble 0 = least significant digit
// One shift per cycle, ValueWidth cycles per conversion. Digits that do not
// fit into NumDigits nibbles are shifted out of the top and lost.
module bin2bcd_serial #(
  parameter int unsigned ValueWidth = 20,
  parameter int unsigned NumDigits  = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [ValueWidth-1:0]  value_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [4*NumDigits-1:0] bcd_o
);

  localparam int unsigned BcdWidth = 4 * NumDigits;
  localparam int unsigned CntWidth = (ValueWidth > 1) ? $clog2(ValueWidth) : 1;

  logic [ValueWidth-1:0] bin_q, bin_d;
  logic [BcdWidth-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  last_iter;

  assign last_iter = busy_q && (cnt_q == CntWidth'(ValueWidth - 1));

  // Add-3 correction so that the following shift carries into the next decade
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(NumDigits); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      bin_d  = value_i;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d = {bcd_adj[BcdWidth-2:0], bin_q[ValueWidth-1]};
      bin_d = {bin_q[ValueWidth-2:0], 1'b0};
      cnt_d = cnt_q + CntWidth'(1);
      if (last_iter) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = last_iter;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/bcd_segment_feeder.sv
// Upstream stage of segment_led: converts a binary value to BCD digits,
// encodes them as 7-segment+dp patterns and drives the digits[] bus, plus
// the periodic next_segment scan strobe.
// Ports:
//   clock, reset_n       clock, asynchronous active-low reset
//   value_in             unsigned value to display
//   dp_in                per-digit decimal point, sampled with value_in
//   blank_leading_zeros  sampled with value_in; 1 = suppress leading zeros
//   value_valid          input bundle valid
//   value_ready          high only while idle
//   update_done          one-cycle pulse on the cycle digits[] changes
//   next_segment         one-cycle scan strobe, every SCAN_DIVIDER cycles
//   digits               encoded patterns, digits[0] = rightmost digit
module bcd_segment_feeder
  import segment_led_pkg::*;
#(
  parameter int unsigned NUMBER_OF_SEGMENTS = 8,
  parameter int unsigned NUMBER_OF_DIGITS   = 6,
  parameter int unsigned VALUE_WIDTH        = 20,
  parameter int unsigned SCAN_DIVIDER       = 12000,
  parameter logic        SEGMENT_ACTIVE_LOW = 1'b0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [VALUE_WIDTH-1:0]        value_in,
  input  logic [NUMBER_OF_DIGITS-1:0]   dp_in,
  input  logic                          blank_leading_zeros,
  input  logic                          value_valid,
  output logic                          value_ready,
  output logic                          update_done,
  output logic                          next_segment,
  output logic [NUMBER_OF_SEGMENTS-1:0] digits [0:NUMBER_OF_DIGITS-1]
);

  localparam longint unsigned MaxValue = pow10(NUMBER_OF_DIGITS) - 64'd1;
  localparam int unsigned     ScanWidth = $clog2(SCAN_DIVIDER);
  localparam logic [NUMBER_OF_SEGMENTS-1:0] BlankPattern =
    SEGMENT_ACTIVE_LOW ? {NUMBER_OF_SEGMENTS{1'b1}} : {NUMBER_OF_SEGMENTS{1'b0}};

  logic [1:0]                    state_q, state_d;
  logic [NUMBER_OF_DIGITS-1:0]   dp_q;
  logic                          blank_q;
  logic                          ovf_q;
  logic                          update_done_q;
  logic [ScanWidth-1:0]          scan_cnt_q, scan_cnt_d;
  logic [NUMBER_OF_SEGMENTS-1:0] digits_q [0:NUMBER_OF_DIGITS-1];
  logic [NUMBER_OF_SEGMENTS-1:0] digits_d [0:NUMBER_OF_DIGITS-1];
  logic [NUMBER_OF_SEGMENTS-1:0] enc      [0:NUMBER_OF_DIGITS-1];

  logic                          transfer;
  logic                          conv_busy, conv_done;
  logic [4*NUMBER_OF_DIGITS-1:0] bcd;
  logic                          scan_last;
  logic                          zero_above;
  logic [3:0]                    nib;
  logic [7:0]                    pat;

  assign value_ready = (state_q == StIdle);
  assign transfer    = value_valid && value_ready;

  bin2bcd_serial #(
    .ValueWidth (VALUE_WIDTH),
    .NumDigits  (NUMBER_OF_DIGITS)
  ) u_bin2bcd (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .start_i (transfer),
    .value_i (value_in),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (transfer) state_d = StShift;
      StShift:  if (conv_done || !conv_busy) state_d = StEncode;
      StEncode: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Walk from the most significant digit down so zero_above tracks "all
  // nibbles from here upward are zero" for leading-zero suppression.
  always_comb begin
    enc        = '{default: '0};
    zero_above = 1'b1;
    nib        = '0;
    pat        = '0;
    for (int i = int'(NUMBER_OF_DIGITS) - 1; i >= 0; i--) begin
      nib        = bcd[4*i +: 4];
      zero_above = zero_above && (nib == 4'd0);
      if (ovf_q) begin
        pat = SEG_MINUS;
      end else if (blank_q && zero_above && (i != 0)) begin
        pat = SEG_BLANK | {dp_q[i], 7'b0};
      end else begin
        pat = seg_font(nib) | {dp_q[i], 7'b0};
      end
      if (SEGMENT_ACTIVE_LOW) pat = ~pat;
      enc[i] = NUMBER_OF_SEGMENTS'(pat);
    end
  end

  // All digits load on the same edge so the panel never shows a mixed value
  always_comb begin
    digits_d = digits_q;
    if (state_q == StEncode) digits_d = enc;
  end

  assign scan_last  = (scan_cnt_q == ScanWidth'(SCAN_DIVIDER - 1));
  assign scan_cnt_d = scan_last ? '0 : scan_cnt_q + ScanWidth'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      dp_q          <= '0;
      blank_q       <= 1'b0;
      ovf_q         <= 1'b0;
      update_done_q <= 1'b0;
      scan_cnt_q    <= '0;
      digits_q      <= '{default: BlankPattern};
    end else begin
      state_q       <= state_d;
      update_done_q <= (state_q == StEncode);
      scan_cnt_q    <= scan_cnt_d;
      digits_q      <= digits_d;
      if (transfer) begin
        dp_q    <= dp_in;
        blank_q <= blank_leading_zeros;
        ovf_q   <= (64'(value_in) > MaxValue);
      end
    end
  end

  assign update_done  = update_done_q;
  assign next_segment = scan_last;
  assign digits       = digits_q;

endmodule
